hr_4t16_demux_align: RTL and testbench
======================================

Name: hr_4t16_demux_align

Overview:
- Receive-side 4:16 half-rate demux. It is the counterpart of the 16:4 transmit mux.
- Each cycle of clk_hr it samples four serial lanes and assembles 16-bit parallel words.
- It aligns the word boundary to a known training pattern using a bit-slip state machine.
- It sits between the 4-lane receive front end and the PRBS checker or parallel data sink.

Parameters:
- ALIGN_PAT, 16'h1E2D: training word. Every 1/2/3-cycle rotation of its four lane nibbles must differ from the pattern itself; the default meets this.
- LOCK_CNT, 4: consecutive pattern matches required to declare lock. Range 1..15.

Ports:
- clk_hr  input  1  receive clock, rising-edge, one lane bit per lane per cycle
- rst  input  1  synchronous reset, active-high
- din  input  4  serial lanes; lane i carries word bits 4i..4i+3
- align_en  input  1  level; high = search for and track ALIGN_PAT
- dout  output  16  assembled word
- dout_valid  output  1  one-cycle pulse per new word on dout
- locked  output  1  high while in LOCKED
- word_phase  output  2  current phase counter ph
- slip_cnt  output  8  slips since reset, saturates at 255

Behaviour:
- Reset: all outputs are 0. ph=0, state=IDLE, match_cnt=0, assembly buffer=0.
- Lane mapping is the inverse of the transmit mux:
  - At phase ph, buf[4i+ph] <= din[i] for i=0..3.
  - Phase 0 is the first bit of the word.
- ph increments mod 4 every cycle unless a slip hold applies.
- Word completion occurs on the edge where ph==3. On that edge:
  - dout <= assembled word, including the current din.
  - The word is compared to ALIGN_PAT in that same cycle.
  - Latency is 1 clk_hr from the last lane bit presented to dout valid.
- dout_valid pulses on the cycle after completion, only when the state at completion is IDLE or LOCKED.
- dout holds its value between completions. It updates in every state.
- Slip:
  - Next ph=0 as usual, then ph is held at 0 for one extra cycle.
  - The bits captured in the held cycle are overwritten.
  - The boundary moves one cycle later.
  - slip_cnt increments, saturating at 255.
- States, evaluated only at word completion unless noted:
  - IDLE: free-running unaligned output. align_en=1 -> SEARCH, with match_cnt=0.
  - SEARCH:
    - Match -> CONFIRM with match_cnt=1, or directly to LOCKED if LOCK_CNT==1.
    - Mismatch -> slip, stay in SEARCH.
  - CONFIRM:
    - Match -> match_cnt+1; reaching LOCK_CNT -> LOCKED.
    - Mismatch -> slip, go to SEARCH with match_cnt=0.
  - LOCKED:
    - locked=1.
    - align_en=1 and mismatch -> slip, go to SEARCH, locked drops the next cycle.
    - align_en=0 -> no comparison; stays LOCKED indefinitely with data passing through.
- align_en=0 while in SEARCH or CONFIRM -> IDLE on the next edge, at any phase. ph and buffer are unchanged; no slip.
- Simultaneous events:
  - Completion and align_en falling in the same cycle: the align_en exit wins, and the word is not compared.
  - A slip hold cycle never coincides with completion.
- rst mid-word or mid-search: state and counters clear on that edge, including slip_cnt. The partial word is discarded and no dout_valid is issued.

Test Plan:
- Reset check: assert rst for 3 cycles with random din -> dout=0, dout_valid=0, locked=0, slip_cnt=0, word_phase=0 throughout.
- IDLE pass-through: align_en=0; drive lanes so the word is 16'hBEEF over cycles 0..3 after reset (lane0 bits F, lane1 E, lane2 E, lane3 B, LSB first) -> dout=16'hBEEF with dout_valid high in cycle 4 only; next pulse in cycle 8.
- Aligned lock: align_en=1 from reset; ALIGN_PAT repeated with a boundary offset of 0 -> no slips, locked rises after the 4th word (cycle 16), then dout_valid pulses every 4 cycles with dout=16'h1E2D, slip_cnt=0.
- Misaligned lock: pattern stream delayed 2 cycles relative to the receive boundary ->
  - Mismatches at words ending cycles 3 and 8, each followed by a slip.
  - Match at the word ending cycle 13; locked after the word ending cycle 25.
  - slip_cnt=2, word_phase=0 on cycle 26.
- Loss of lock: locked with align_en=1, inject one corrupted word (16'h1E2C) -> locked=0 the next cycle, slip_cnt increments by 1, relock after re-alignment. Repeat with align_en=0 -> locked stays 1 and dout=16'h1E2C with dout_valid.
- Mid-operation events:
  - align_en drops in CONFIRM (match_cnt=2) -> IDLE the next cycle, no slip.
  - rst asserted at ph=2 while in SEARCH -> all outputs 0, ph restarts at 0, slip_cnt=0.

Source files
------------

// File: rtl/hr_4t16_demux_align.sv
// Half-rate 4:16 receive demux with bit-slip word alignment.
// Four serial lanes are deserialised into 16-bit words. A training-pattern
// state machine slips the word boundary one cycle at a time until ALIGN_PAT
// is seen LOCK_CNT times in a row.
module hr_4t16_demux_align #(
  parameter logic [15:0] ALIGN_PAT = 16'h1E2D,
  parameter int unsigned LOCK_CNT  = 4
) (
  input  logic        clk_hr,
  input  logic        rst,
  input  logic [3:0]  din,
  input  logic        align_en,
  output logic [15:0] dout,
  output logic        dout_valid,
  output logic        locked,
  output logic [1:0]  word_phase,
  output logic [7:0]  slip_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEARCH  = 2'd1,
    CONFIRM = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  localparam logic [3:0] LC = 4'(LOCK_CNT);

  state_t      r_state;
  logic [1:0]  r_ph;
  logic        r_hold;
  logic [15:0] r_buf;
  logic [15:0] r_dout;
  logic        r_valid;
  logic        r_locked;
  logic [3:0]  r_matchCnt;
  logic [7:0]  r_slipCnt;

  logic [15:0] w_word;
  logic        w_complete;
  logic        w_match;
  logic        w_slip;

  // Completed word: buffered bits of phases 0..2 merged with the live phase-3 lane bits
  always_comb begin
    w_word = r_buf;
    for (int i = 0; i < 4; i++) begin
      w_word[{i[1:0], 2'd3}] = din[i];
    end
  end

  // A hold cycle always sits at phase 0, so it can never coincide with a completion.
  // Slips only happen while aligning; with align_en low, SEARCH/CONFIRM exit instead.
  assign w_complete = (r_ph == 2'd3);
  assign w_match    = (w_word == ALIGN_PAT);
  assign w_slip     = w_complete && !w_match && align_en && (r_state != IDLE);

  // Datapath: lane capture, phase counter with slip hold, output word and valid pulse
  always_ff @(posedge clk_hr) begin
    if (rst) begin
      r_ph    <= 2'd0;
      r_hold  <= 1'b0;
      r_buf   <= 16'h0000;
      r_dout  <= 16'h0000;
      r_valid <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_buf[{i[1:0], r_ph}] <= din[i];
      end
      if (r_hold) begin
        r_ph   <= 2'd0;
        r_hold <= 1'b0;
      end else begin
        r_ph   <= r_ph + 2'd1;
        r_hold <= w_slip;
      end
      if (w_complete) begin
        r_dout <= w_word;
      end
      r_valid <= w_complete && ((r_state == IDLE) || (r_state == LOCKED));
    end
  end

  // Alignment FSM: search, confirm and track the training pattern; counts slips
  always_ff @(posedge clk_hr) begin
    if (rst) begin
      r_state    <= IDLE;
      r_matchCnt <= 4'd0;
      r_slipCnt  <= 8'd0;
      r_locked   <= 1'b0;
    end else begin
      if (w_slip && (r_slipCnt != 8'hFF)) begin
        r_slipCnt <= r_slipCnt + 8'd1;
      end
      case (r_state)
        IDLE: begin
          if (align_en) begin
            r_state    <= SEARCH;
            r_matchCnt <= 4'd0;
          end
        end
        SEARCH: begin
          if (!align_en) begin
            r_state <= IDLE;
          end else if (w_complete && w_match) begin
            r_matchCnt <= 4'd1;
            if (LC == 4'd1) begin
              r_state  <= LOCKED;
              r_locked <= 1'b1;
            end else begin
              r_state <= CONFIRM;
            end
          end
        end
        CONFIRM: begin
          if (!align_en) begin
            r_state <= IDLE;
          end else if (w_complete) begin
            if (w_match) begin
              r_matchCnt <= r_matchCnt + 4'd1;
              if ((r_matchCnt + 4'd1) == LC) begin
                r_state  <= LOCKED;
                r_locked <= 1'b1;
              end
            end else begin
              r_state    <= SEARCH;
              r_matchCnt <= 4'd0;
            end
          end
        end
        LOCKED: begin
          if (w_slip) begin
            r_state    <= SEARCH;
            r_matchCnt <= 4'd0;
            r_locked   <= 1'b0;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign locked     = r_locked;
  assign word_phase = r_ph;
  assign slip_cnt   = r_slipCnt;

endmodule

// File: tb/tb_hr_4t16_demux_align.sv
// Self-checking bench for hr_4t16_demux_align: directed scenarios followed by
// randomized traffic, all compared against a bit-collecting reference model.
module tb_hr_4t16_demux_align;

  localparam logic [15:0] PAT   = 16'h1E2D;
  localparam logic [15:0] BAD   = 16'h1E2C;
  localparam int          LOCKN = 4;
  localparam int M_IDLE = 0, M_SEARCH = 1, M_CONFIRM = 2, M_LOCKED = 3;

  logic        clk_hr = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  din = 4'd0;
  logic        align_en = 1'b0;
  logic [15:0] dout;
  logic        dout_valid;
  logic        locked;
  logic [1:0]  word_phase;
  logic [7:0]  slip_cnt;

  int nChecks = 0;
  int nFail = 0;

  // reference model: bits collected into the current word, pending discard after a slip
  int          mPos;
  bit          mDiscard;
  logic [15:0] mWord;
  int          mMode;
  int          mMatches;
  logic [15:0] eDout;
  logic        eValid;
  logic        eLocked;
  int          eSlip;

  int corruptA = -1;
  int corruptB = -1;

  always #5 clk_hr = ~clk_hr;

  hr_4t16_demux_align #(.ALIGN_PAT(PAT), .LOCK_CNT(LOCKN)) dut (
    .clk_hr    (clk_hr),
    .rst       (rst),
    .din       (din),
    .align_en  (align_en),
    .dout      (dout),
    .dout_valid(dout_valid),
    .locked    (locked),
    .word_phase(word_phase),
    .slip_cnt  (slip_cnt)
  );

  function automatic logic [3:0] laneBits(input logic [15:0] w, input int p);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = w[4*i+p];
    return r;
  endfunction

  function automatic logic [15:0] wordAt(input int k);
    return ((k == corruptA) || (k == corruptB)) ? BAD : PAT;
  endfunction

  // stream bit s of a word train; bits before the train starts are noise
  function automatic logic [3:0] streamDin(input int s);
    if (s < 0) return 4'($urandom);
    return laneBits(wordAt(s / 4), s % 4);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelSlip();
    mDiscard = 1'b1;
    if (eSlip < 255) eSlip++;
  endtask

  task automatic modelStep(input logic r, input logic [3:0] d, input logic en);
    bit done;
    bit hit;
    if (r) begin
      mPos = 0; mDiscard = 0; mWord = 16'h0; mMode = M_IDLE; mMatches = 0;
      eDout = 16'h0; eValid = 0; eLocked = 0; eSlip = 0;
      return;
    end
    done = 0;
    eValid = 0;
    if (mDiscard) begin
      mDiscard = 0;
    end else begin
      for (int i = 0; i < 4; i++) mWord[4*i+mPos] = d[i];
      done = (mPos == 3);
      mPos = (mPos + 1) % 4;
    end
    if (done) eDout = mWord;
    hit = (mWord == PAT);
    if (((mMode == M_SEARCH) || (mMode == M_CONFIRM)) && !en) begin
      mMode = M_IDLE;
    end else if (done) begin
      eValid = (mMode == M_IDLE) || (mMode == M_LOCKED);
      case (mMode)
        M_IDLE: if (en) begin mMode = M_SEARCH; mMatches = 0; end
        M_SEARCH: begin
          if (hit) begin
            mMatches = 1;
            mMode = (LOCKN == 1) ? M_LOCKED : M_CONFIRM;
          end else modelSlip();
        end
        M_CONFIRM: begin
          if (hit) begin
            mMatches++;
            if (mMatches == LOCKN) mMode = M_LOCKED;
          end else begin
            modelSlip(); mMode = M_SEARCH; mMatches = 0;
          end
        end
        default: if (en && !hit) begin modelSlip(); mMode = M_SEARCH; mMatches = 0; end
      endcase
    end else if ((mMode == M_IDLE) && en) begin
      mMode = M_SEARCH; mMatches = 0;
    end
    eLocked = (mMode == M_LOCKED);
  endtask

  // drive one cycle away from the edge, then compare every output with the model
  task automatic applyStimulus(input logic r, input logic [3:0] d, input logic en);
    @(negedge clk_hr);
    rst = r; din = d; align_en = en;
    @(posedge clk_hr);
    #1;
    modelStep(r, d, en);
    checkOutput("dout", 32'(dout), 32'(eDout));
    checkOutput("dout_valid", 32'(dout_valid), 32'(eValid));
    checkOutput("locked", 32'(locked), 32'(eLocked));
    checkOutput("word_phase", 32'(word_phase), 32'(mPos));
    checkOutput("slip_cnt", 32'(slip_cnt), 32'(eSlip));
  endtask

  task automatic doReset(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, 4'($urandom), 1'b0);
  endtask

  initial begin
    logic        en;
    logic        r;
    logic        patMode;
    logic [15:0] curWord;
    int          sCnt;

    // reset with noisy lanes: everything reads zero
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 4'($urandom), 1'b0);
      checkOutput("rst_dout", 32'(dout), 32'h0);
      checkOutput("rst_valid", 32'(dout_valid), 32'h0);
      checkOutput("rst_locked", 32'(locked), 32'h0);
      checkOutput("rst_slip", 32'(slip_cnt), 32'h0);
      checkOutput("rst_phase", 32'(word_phase), 32'h0);
    end

    // free-running pass-through of 16'hBEEF
    for (int c = 0; c < 9; c++) begin
      applyStimulus(1'b0, laneBits(16'hBEEF, c % 4), 1'b0);
      if (c == 3 || c == 7) begin
        checkOutput("idle_dout", 32'(dout), 32'hBEEF);
        checkOutput("idle_valid_hi", 32'(dout_valid), 32'h1);
      end else begin
        checkOutput("idle_valid_lo", 32'(dout_valid), 32'h0);
      end
    end

    // aligned training stream locks without slipping
    doReset(2);
    for (int c = 0; c < 24; c++) begin
      applyStimulus(1'b0, streamDin(c), 1'b1);
      if (c == 14) checkOutput("align_not_yet", 32'(locked), 32'h0);
      if (c == 15) checkOutput("align_locked", 32'(locked), 32'h1);
      if (c == 18) checkOutput("align_valid_gap", 32'(dout_valid), 32'h0);
      if (c == 19) begin
        checkOutput("align_valid", 32'(dout_valid), 32'h1);
        checkOutput("align_dout", 32'(dout), 32'(PAT));
        checkOutput("align_slip", 32'(slip_cnt), 32'h0);
      end
    end

    // stream delayed by 2 cycles, then loss of lock with and without align_en
    doReset(2);
    corruptA = 7;
    corruptB = 17;
    for (int c = 0; c < 80; c++) begin
      applyStimulus(1'b0, streamDin(c - 2), (c < 66));
      if (c == 3) checkOutput("mis_slip1", 32'(slip_cnt), 32'h1);
      if (c == 8) checkOutput("mis_slip2", 32'(slip_cnt), 32'h2);
      if (c == 24) checkOutput("mis_not_yet", 32'(locked), 32'h0);
      if (c == 25) begin
        checkOutput("mis_locked", 32'(locked), 32'h1);
        checkOutput("mis_slipcnt", 32'(slip_cnt), 32'h2);
        checkOutput("mis_phase", 32'(word_phase), 32'h0);
      end
      if (c == 33) begin
        checkOutput("loss_locked", 32'(locked), 32'h0);
        checkOutput("loss_slip", 32'(slip_cnt), 32'h3);
      end
      if (c == 65) begin
        checkOutput("relock", 32'(locked), 32'h1);
        checkOutput("relock_slip", 32'(slip_cnt), 32'h6);
      end
      if (c == 73) begin
        checkOutput("noalign_locked", 32'(locked), 32'h1);
        checkOutput("noalign_dout", 32'(dout), 32'(BAD));
        checkOutput("noalign_valid", 32'(dout_valid), 32'h1);
        checkOutput("noalign_slip", 32'(slip_cnt), 32'h6);
      end
    end
    corruptA = -1;
    corruptB = -1;

    // align_en falls in CONFIRM with two matches
    doReset(2);
    for (int c = 0; c < 13; c++) begin
      applyStimulus(1'b0, streamDin(c), (c < 9));
      if (c == 7) checkOutput("conf_locked", 32'(locked), 32'h0);
      if (c == 9) begin
        checkOutput("drop_slip", 32'(slip_cnt), 32'h0);
        checkOutput("drop_phase", 32'(word_phase), 32'h2);
      end
      if (c == 11) begin
        checkOutput("drop_idle_valid", 32'(dout_valid), 32'h1);
        checkOutput("drop_idle_dout", 32'(dout), 32'(PAT));
      end
    end

    // reset at phase 2 while searching
    doReset(2);
    for (int c = 0; c < 10; c++) begin
      applyStimulus((c == 7), streamDin(c - 2), (c < 7));
      if (c == 3) checkOutput("srch_slip", 32'(slip_cnt), 32'h1);
      if (c == 6) checkOutput("srch_phase", 32'(word_phase), 32'h2);
      if (c == 7) begin
        checkOutput("midrst_phase", 32'(word_phase), 32'h0);
        checkOutput("midrst_slip", 32'(slip_cnt), 32'h0);
        checkOutput("midrst_dout", 32'(dout), 32'h0);
      end
      if (c == 8) checkOutput("midrst_restart", 32'(word_phase), 32'h1);
    end

    // noise with alignment enabled drives slip_cnt into saturation
    doReset(2);
    for (int c = 0; c < 1400; c++) applyStimulus(1'b0, 4'($urandom), 1'b1);
    checkOutput("slip_saturate", 32'(slip_cnt), 32'd255);

    // randomized mix of training traffic, noise, align_en toggles and resets
    doReset(2);
    en = 1'b1;
    patMode = 1'b1;
    sCnt = 0;
    curWord = PAT;
    for (int n = 0; n < 1500; n++) begin
      if (n % 100 == 0) patMode = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 39) == 0) en = ~en;
      if ($urandom_range(0, 149) == 0) sCnt++;
      r = ($urandom_range(0, 249) == 0);
      if (sCnt % 4 == 0) curWord = ($urandom_range(0, 19) == 0) ? 16'($urandom) : PAT;
      applyStimulus(r, patMode ? laneBits(curWord, sCnt % 4) : 4'($urandom), en);
      sCnt++;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
